// File: rtl/sample_unpacker_pkg.sv
// Shared GPS front-end constants: default packet/sample widths and unpacker state encodings.
package sample_unpacker_pkg;

  localparam int WORD_W_DEF   = 16;
  localparam int SAMPLE_W_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int buf_width(input int word_w, input int sample_w);
    return word_w + sample_w - 1;
  endfunction

endpackage

// File: rtl/sample_unpacker_bit_accumulator.sv
// LSB-first bit buffer: shifts a sample out of the bottom and appends a word at the current fill level.
module sample_unpacker_bit_accumulator
  import sample_unpacker_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BUF_W    = buf_width(WORD_W, SAMPLE_W),
  parameter int CNT_W    = $clog2(BUF_W + 1)
) (
  input  logic                clk_sample,
  input  logic                reset,
  input  logic                flush,
  input  logic                shift,
  input  logic                append,
  input  logic [WORD_W-1:0]   append_data,
  output logic [SAMPLE_W-1:0] head,
  output logic [CNT_W-1:0]    level,
  output logic [CNT_W-1:0]    remain
);

  logic [BUF_W-1:0] bits;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] bits_next;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] count_next;

  assign head   = bits[SAMPLE_W-1:0];
  assign level  = bit_count;
  assign remain = shift ? (bit_count - CNT_W'(SAMPLE_W)) : bit_count;

  // Bits above bit_count are always zero, so appending is a plain OR at offset remain.
  always_comb begin
    shifted    = shift ? (bits >> SAMPLE_W) : bits;
    bits_next  = shifted;
    count_next = remain;
    if (append) begin
      bits_next  = shifted | (BUF_W'(append_data) << remain);
      count_next = remain + CNT_W'(WORD_W);
    end
  end

  always_ff @(posedge clk_sample) begin
    if (reset || flush) begin
      bits      <= '0;
      bit_count <= '0;
    end else begin
      bits      <= bits_next;
      bit_count <= count_next;
    end
  end

endmodule

// File: rtl/sample_unpacker.sv
// Unpacks fixed-width packet words from a FWFT FIFO into a registered SAMPLE_W-bit sample stream.
module sample_unpacker
  import sample_unpacker_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int UCNT_W   = 16
) (
  input  logic                clk_sample,
  input  logic                reset,
  input  logic                resync,
  input  logic                packet_empty,
  input  logic [WORD_W-1:0]   packet_data,
  output logic                packet_read,
  input  logic                sample_ready,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [31:0]         total_sample_count,
  output logic [UCNT_W-1:0]   underflow_count
);

  localparam int BUF_W = buf_width(WORD_W, SAMPLE_W);
  localparam int CNT_W = $clog2(BUF_W + 1);

  state_t              state;
  state_t              state_next;
  logic [SAMPLE_W-1:0] head;
  logic [CNT_W-1:0]    level;
  logic [CNT_W-1:0]    remain;
  logic                out_load;
  logic                accept;

  assign accept      = sample_valid && sample_ready;
  assign out_load    = (level >= CNT_W'(SAMPLE_W)) && (!sample_valid || sample_ready);
  assign packet_read = !packet_empty && !resync && !reset && (remain < CNT_W'(SAMPLE_W));

  sample_unpacker_bit_accumulator #(
    .WORD_W   (WORD_W),
    .SAMPLE_W (SAMPLE_W),
    .BUF_W    (BUF_W),
    .CNT_W    (CNT_W)
  ) u_bit_accumulator (
    .clk_sample  (clk_sample),
    .reset       (reset),
    .flush       (resync),
    .shift       (out_load),
    .append      (packet_read),
    .append_data (packet_data),
    .head        (head),
    .level       (level),
    .remain      (remain)
  );

  always_ff @(posedge clk_sample) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (resync)                         state_next = ST_IDLE;
    else if (state == ST_IDLE && accept) state_next = ST_RUN;
  end

  // resync drops the pending sample but leaves sample_data as last presented.
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else if (resync) begin
      sample_valid <= 1'b0;
    end else if (out_load) begin
      sample_valid <= 1'b1;
      sample_data  <= head;
    end else if (accept) begin
      sample_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (reset) begin
      total_sample_count <= '0;
      underflow_count    <= '0;
    end else begin
      if (accept) total_sample_count <= total_sample_count + 32'd1;
      if (state == ST_RUN && !sample_valid && sample_ready && underflow_count != '1)
        underflow_count <= underflow_count + UCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_unpacker.sv
// Directed bench for sample_unpacker: default 16/3 instance plus 8/8 and 16/1 width variants.
module tb_sample_unpacker;

  logic clk_sample = 1'b0;
  always #5 clk_sample = ~clk_sample;

  logic        reset, resync, packet_empty, sample_ready;
  logic [15:0] packet_data;
  logic        packet_read, sample_valid;
  logic [2:0]  sample_data;
  logic [31:0] total_sample_count;
  logic [15:0] underflow_count;

  sample_unpacker dut (
    .clk_sample(clk_sample), .reset(reset), .resync(resync),
    .packet_empty(packet_empty), .packet_data(packet_data), .packet_read(packet_read),
    .sample_ready(sample_ready), .sample_valid(sample_valid), .sample_data(sample_data),
    .total_sample_count(total_sample_count), .underflow_count(underflow_count)
  );

  logic        reset8, read8, valid8;
  logic [7:0]  data8, sdata8;
  logic [31:0] total8;
  logic [15:0] under8;

  sample_unpacker #(.WORD_W(8), .SAMPLE_W(8)) dut8 (
    .clk_sample(clk_sample), .reset(reset8), .resync(1'b0),
    .packet_empty(1'b0), .packet_data(data8), .packet_read(read8),
    .sample_ready(1'b1), .sample_valid(valid8), .sample_data(sdata8),
    .total_sample_count(total8), .underflow_count(under8)
  );

  logic        reset1, read1, valid1;
  logic [15:0] data1;
  logic [0:0]  sdata1;
  logic [31:0] total1;
  logic [15:0] under1;

  sample_unpacker #(.WORD_W(16), .SAMPLE_W(1)) dut1 (
    .clk_sample(clk_sample), .reset(reset1), .resync(1'b0),
    .packet_empty(1'b0), .packet_data(data1), .packet_read(read1),
    .sample_ready(1'b1), .sample_valid(valid1), .sample_data(sdata1),
    .total_sample_count(total1), .underflow_count(under1)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] stream_w[$];
  int          got[$];
  int          pop_cyc[$];
  int          pops, cyc;
  logic        last_rd, last_sv, force_empty;

  // Reference: LSB-first bit stream of stream_w cut into 3-bit samples.
  function automatic int exp_sample(input int idx);
    int v, b;
    logic [15:0] w;
    v = 0;
    for (int j = 0; j < 3; j++) begin
      b = idx * 3 + j;
      if (b / 16 < stream_w.size()) begin
        w = stream_w[b / 16];
        v = v | (int'(w[b % 16]) << j);
      end
    end
    return v;
  endfunction

  task automatic tick();
    packet_empty = force_empty || (fifo_q.size() == 0);
    packet_data  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
    #4;
    last_rd = packet_read;
    last_sv = sample_valid;
    if (sample_valid && sample_ready) got.push_back(int'(sample_data));
    if (packet_read) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    @(posedge clk_sample); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; resync = 1'b0; sample_ready = 1'b1; force_empty = 1'b0;
    fifo_q.delete(); stream_w.delete(); got.delete(); pop_cyc.delete();
    tick(); tick();
    reset = 1'b0; pops = 0; cyc = 0; got.delete(); pop_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; resync = 1'b0; sample_ready = 1'b1; force_empty = 1'b0;
    fifo_q.delete(); got.delete(); pop_cyc.delete();
    fifo_q.push_back(16'hEB1A);
    tick();
    checks++; if (last_rd !== 1'b0) begin failures++; $display("FAIL reset_no_pop: got %0b want 0", last_rd); end
    tick();
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", sample_valid); end
    checks++; if (sample_data !== 3'd0) begin failures++; $display("FAIL reset_data: got %0d want 0", sample_data); end
    checks++; if (total_sample_count !== 32'd0) begin failures++; $display("FAIL reset_total: got %0d want 0", total_sample_count); end
    checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL reset_underflow: got %0d want 0", underflow_count); end
    reset = 1'b0;
    tick();
    checks++; if (last_rd !== 1'b1) begin failures++; $display("FAIL reset_release_pop: got %0b want 1", last_rd); end
    tick();
    checks++; if (sample_valid !== 1'b1 || sample_data !== 3'd2) begin
      failures++; $display("FAIL reset_first_sample: got v=%0b d=%0d want v=1 d=2", sample_valid, sample_data); end
  endtask

  task automatic test_straddle();
    int first_pop, first_valid;
    int exp_s[10] = '{2, 3, 4, 5, 6, 1, 0, 0, 0, 0};
    do_reset();
    fifo_q.push_back(16'hEB1A); fifo_q.push_back(16'h0000);
    first_pop = -1; first_valid = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_rd && first_pop < 0) first_pop = cyc - 1;
      if (last_sv && first_valid < 0) first_valid = cyc - 1;
    end
    checks++; if (first_valid - first_pop !== 2) begin
      failures++; $display("FAIL straddle_latency: got %0d want 2", first_valid - first_pop); end
    checks++; if (got.size() !== 10) begin failures++; $display("FAIL straddle_count: got %0d want 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_s[i]) begin
        failures++; $display("FAIL straddle_sample[%0d]: got %0d want %0d", i, got[i], exp_s[i]); end
    end
    checks++; if (total_sample_count !== 32'd10) begin
      failures++; $display("FAIL straddle_total: got %0d want 10", total_sample_count); end
  endtask

  task automatic test_throughput();
    int p0, bubbles, guard;
    logic [31:0] t0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      fifo_q.push_back(16'(16'h1357 * (k + 1) ^ 16'hA5C3));
      stream_w.push_back(16'(16'h1357 * (k + 1) ^ 16'hA5C3));
    end
    guard = 0;
    do begin tick(); guard++; end while (!last_sv && guard < 10);
    checks++; if (!last_sv) begin failures++; $display("FAIL thru_start: got no valid want valid within 10 cycles"); end
    p0 = pops; t0 = total_sample_count; bubbles = 0;
    repeat (48) begin tick(); if (!last_sv) bubbles++; end
    checks++; if (pops - p0 !== 9) begin failures++; $display("FAIL thru_pops: got %0d want 9", pops - p0); end
    checks++; if (bubbles !== 0) begin failures++; $display("FAIL thru_bubbles: got %0d want 0", bubbles); end
    checks++; if (total_sample_count - t0 !== 32'd48) begin
      failures++; $display("FAIL thru_total: got %0d want 48", total_sample_count - t0); end
    if (pop_cyc.size() >= 4) begin
      checks++; if (pop_cyc[1] - pop_cyc[0] !== 5 || pop_cyc[2] - pop_cyc[1] !== 5 || pop_cyc[3] - pop_cyc[2] !== 6) begin
        failures++; $display("FAIL thru_spacing: got %0d,%0d,%0d want 5,5,6",
          pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1], pop_cyc[3] - pop_cyc[2]); end
    end else begin
      checks++; failures++; $display("FAIL thru_spacing: got %0d pops want at least 4", pop_cyc.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_sample(i)) begin
        failures++; $display("FAIL thru_sample[%0d]: got %0d want %0d", i, got[i], exp_sample(i)); end
    end
  endtask

  task automatic test_backpressure();
    int p0, guard, n;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      fifo_q.push_back(16'h9E37 + 16'(k * 16'h0F1D));
      stream_w.push_back(16'h9E37 + 16'(k * 16'h0F1D));
    end
    guard = 0;
    while (got.size() < 3 && guard < 20) begin tick(); guard++; end
    sample_ready = 1'b0; p0 = pops; n = got.size();
    repeat (4) begin
      tick();
      checks++; if (sample_valid !== 1'b1 || int'(sample_data) !== exp_sample(n)) begin
        failures++; $display("FAIL stall_hold: got v=%0b d=%0d want v=1 d=%0d", sample_valid, sample_data, exp_sample(n)); end
    end
    checks++; if (pops - p0 > 1) begin failures++; $display("FAIL stall_pops: got %0d want <=1", pops - p0); end
    checks++; if (got.size() !== n) begin failures++; $display("FAIL stall_accepts: got %0d want %0d", got.size(), n); end
    sample_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_sample(i)) begin
        failures++; $display("FAIL stall_sample[%0d]: got %0d want %0d", i, got[i], exp_sample(i)); end
    end
    checks++; if (total_sample_count !== 32'(got.size())) begin
      failures++; $display("FAIL stall_total: got %0d want %0d", total_sample_count, got.size()); end
  endtask

  task automatic test_underflow();
    logic seen;
    do_reset();
    repeat (5) tick();
    checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL underflow_idle: got %0d want 0", underflow_count); end
    fifo_q.push_back(16'hEB1A); stream_w.push_back(16'hEB1A);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_sv) seen = 1'b1;
      else if (seen) break;
    end
    tick(); tick();
    checks++; if (underflow_count !== 16'd3) begin failures++; $display("FAIL underflow_run: got %0d want 3", underflow_count); end
    checks++; if (total_sample_count !== 32'd5) begin failures++; $display("FAIL underflow_total: got %0d want 5", total_sample_count); end
  endtask

  task automatic test_resync();
    int guard;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fifo_q.push_back(16'h5A3C ^ 16'(k * 16'h1111));
      stream_w.push_back(16'h5A3C ^ 16'(k * 16'h1111));
    end
    guard = 0;
    do begin tick(); guard++; end while (!last_rd && guard < 5);
    tick(); tick(); tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    checks++; if (last_rd !== 1'b0) begin failures++; $display("FAIL resync_no_pop: got %0b want 0", last_rd); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL resync_valid: got %0b want 0", sample_valid); end
    checks++; if (int'(sample_data) !== exp_sample(2)) begin
      failures++; $display("FAIL resync_data_kept: got %0d want %0d", sample_data, exp_sample(2)); end
    checks++; if (total_sample_count !== 32'd3) begin failures++; $display("FAIL resync_total: got %0d want 3", total_sample_count); end
    void'(stream_w.pop_front());
    got.delete();
    repeat (12) tick();
    checks++; if (got.size() !== 10) begin failures++; $display("FAIL resync_count: got %0d want 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp_sample(i)) begin
        failures++; $display("FAIL resync_sample[%0d]: got %0d want %0d", i, got[i], exp_sample(i)); end
    end
    checks++; if (total_sample_count !== 32'd13) begin failures++; $display("FAIL resync_total_after: got %0d want 13", total_sample_count); end
    checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL resync_underflow: got %0d want 0", underflow_count); end
  endtask

  task automatic test_width_variants();
    logic [7:0]  w8[4];
    logic [15:0] w1[2];
    logic [15:0] cur;
    int i8, i1;
    int g8[$];
    int g1[$];
    w8[0] = 8'h3C; w8[1] = 8'hA5; w8[2] = 8'h01; w8[3] = 8'hFF;
    w1[0] = 16'hEB1A; w1[1] = 16'h8001;
    i8 = 0; i1 = 0;
    reset8 = 1'b0; reset1 = 1'b0;
    repeat (40) begin
      data8 = w8[i8 % 4];
      data1 = w1[i1 % 2];
      #4;
      if (valid8) g8.push_back(int'(sdata8));
      if (valid1) g1.push_back(int'(sdata1));
      if (read8) i8++;
      if (read1) i1++;
      @(posedge clk_sample); #1;
    end
    checks++; if (g8.size() !== 38) begin failures++; $display("FAIL w8_count: got %0d want 38", g8.size()); end
    for (int i = 0; i < g8.size(); i++) begin
      checks++; if (g8[i] !== int'(w8[i % 4])) begin
        failures++; $display("FAIL w8_sample[%0d]: got %0d want %0d", i, g8[i], w8[i % 4]); end
    end
    checks++; if (g1.size() !== 38) begin failures++; $display("FAIL w1_count: got %0d want 38", g1.size()); end
    for (int i = 0; i < g1.size(); i++) begin
      cur = w1[(i / 16) % 2];
      checks++; if (g1[i] !== int'(cur[i % 16])) begin
        failures++; $display("FAIL w1_sample[%0d]: got %0d want %0d", i, g1[i], cur[i % 16]); end
    end
  endtask

  initial begin
    reset = 1'b1; resync = 1'b0; packet_empty = 1'b1; packet_data = '0;
    sample_ready = 1'b1; force_empty = 1'b0; pops = 0; cyc = 0;
    last_rd = 1'b0; last_sv = 1'b0;
    reset8 = 1'b1; reset1 = 1'b1; data8 = '0; data1 = '0;
    @(posedge clk_sample); #1;
    test_reset();
    test_straddle();
    test_throughput();
    test_backpressure();
    test_underflow();
    test_resync();
    test_width_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
